// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with exact occupancy, programmable almost flags and overflow/underflow pulses.
// Optional per-word even parity when SYNC_FIFO_PARITY_EN is defined.
module sync_fifo_prog #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          FWFT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   prog_full_thresh,
    input  logic [ADDR_WIDTH:0]   prog_empty_thresh,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow,
`ifdef SYNC_FIFO_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
`ifdef SYNC_FIFO_PARITY_EN
    localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
    localparam int unsigned MEM_W = DATA_WIDTH;
`endif

    logic [MEM_W-1:0]      mem [DEPTH];
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      head_word;
    logic [MEM_W-1:0]      out_word;
    logic [MEM_W-1:0]      hold_q;
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] rptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  valid_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  wr_acc;
    logic                  rd_acc;

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {^din, din};
`else
    assign wr_word = din;
`endif

    assign wr_acc    = wr_en & ~full;
    assign rd_acc    = rd_en & ~empty;
    assign head_word = mem[rptr_q];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q] <= wr_word;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rptr_q <= rptr_q + ADDR_WIDTH'(1);
                hold_q <= head_word;
            end
            count_q <= count_d;
            valid_q <= rd_acc;
            ovf_q   <= wr_en & full;
            unf_q   <= rd_en & empty;
        end
    end

    assign full         = (count_q == FULL_COUNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= prog_full_thresh);
    assign almost_empty = (count_q <= prog_empty_thresh);
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // FWFT shows the head word live; hold_q keeps the last popped word for the empty case.
    always_comb begin
        if (FWFT_EN) begin
            out_word   = empty ? hold_q : head_word;
            dout_valid = ~empty;
        end else begin
            out_word   = hold_q;
            dout_valid = valid_q;
        end
    end

    assign dout = out_word[DATA_WIDTH-1:0];

`ifdef SYNC_FIFO_PARITY_EN
    assign parity_err = dout_valid & (^out_word);
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: an FWFT instance and a standard-read instance on one clock.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din, s_din;
    logic       wr_en, rd_en, s_wr_en, s_rd_en;
    logic [4:0] pf_th, pe_th;
    logic [7:0] dout, s_dout;
    logic       dout_valid, full, empty, af, ae, ovf, unf;
    logic       s_dout_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0] count, s_count;
`ifdef SYNC_FIFO_PARITY_EN
    logic       perr, s_perr;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .prog_full_thresh(pf_th), .prog_empty_thresh(pe_th),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(af), .almost_empty(ae), .data_count(count),
        .overflow(ovf),
`ifdef SYNC_FIFO_PARITY_EN
        .parity_err(perr),
`endif
        .underflow(unf)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(1'b0)) u_std (
        .clk(clk), .rst(rst), .din(s_din), .wr_en(s_wr_en), .rd_en(s_rd_en),
        .prog_full_thresh(pf_th), .prog_empty_thresh(pe_th),
        .dout(s_dout), .dout_valid(s_dout_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .data_count(s_count),
        .overflow(s_ovf),
`ifdef SYNC_FIFO_PARITY_EN
        .parity_err(s_perr),
`endif
        .underflow(s_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1;
            din   = 8'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        s_din = '0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        pf_th = 5'd12; pe_th = 5'd3;

        do_reset();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ae", 32'(ae), 1);
        check("rst_full", 32'(full), 0);
        check("rst_af", 32'(af), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_unf", 32'(unf), 0);
        check("std_rst_dout", 32'(s_dout), 0);

        // Standard read: one cycle latency, single-cycle valid.
        s_wr_en = 1'b1; s_din = 8'h5a; step(); s_wr_en = 1'b0;
        check("std_no_valid_yet", 32'(s_dout_valid), 0);
        s_rd_en = 1'b1; step(); s_rd_en = 1'b0;
        check("std_dout", 32'(s_dout), 32'h5a);
        check("std_valid", 32'(s_dout_valid), 1);
        step();
        check("std_valid_drop", 32'(s_dout_valid), 0);
        check("std_dout_hold", 32'(s_dout), 32'h5a);
        check("std_empty", 32'(s_empty), 1);

        // Fill with 0x01..0x10, watching count and almost_full.
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; din = 8'(i); step();
            check("fill_count", 32'(count), 32'(i));
            check("fill_af", 32'(af), 32'(i >= 12));
        end
        wr_en = 1'b0;
        check("fill_full", 32'(full), 1);
        wr_en = 1'b1; din = 8'haa; step(); wr_en = 1'b0;
        check("ovf_pulse", 32'(ovf), 1);
        check("ovf_count", 32'(count), 16);
        step();
        check("ovf_drop", 32'(ovf), 0);

        // Drain: each head word visible before its acknowledge.
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            check("drain_dout", 32'(dout), 32'(i));
            step();
        end
        check("drain_empty", 32'(empty), 1);
        step();
        rd_en = 1'b0;
        check("unf_pulse", 32'(unf), 1);
        check("unf_dout_hold", 32'(dout), 32'h10);
        step();
        check("unf_drop", 32'(unf), 0);

        // Simultaneous requests at full and at empty.
        fill16();
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h77; step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("both_full_count", 32'(count), 15);
        check("both_full_ovf", 32'(ovf), 1);
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) step();
        rd_en = 1'b0;
        check("drained", 32'(count), 0);
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h44; step();
        rd_en = 1'b0;
        check("both_empty_count", 32'(count), 1);
        check("both_empty_unf", 32'(unf), 1);
        check("both_empty_dout", 32'(dout), 32'h44);
        q.delete();
        q.push_back(8'h44);
        for (int i = 0; i < 6; i++) begin
            din = 8'(8'h45 + i); q.push_back(din); step();
        end
        wr_en = 1'b0;
        check("count7", 32'(count), 7);

        // Hold count at 7 for 20 cycles so both pointers wrap.
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'h50 + k);
            check("wrap_dout", 32'(dout), 32'(q[0]));
            void'(q.pop_front());
            q.push_back(din);
            step();
            check("wrap_count", 32'(count), 7);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("wrap_head", 32'(dout), 32'(q[0]));

        // Threshold of 0 pins almost_full high.
        pf_th = 5'd0;
        do_reset();
        check("af_thresh0", 32'(af), 1);
        pf_th = 5'd12;

        // almost_empty sweep across thresholds 0, 5, 16.
        for (int t = 0; t < 3; t++) begin
            pe_th = (t == 0) ? 5'd0 : (t == 1) ? 5'd5 : 5'd16;
            do_reset();
            check("ae_sweep0", 32'(ae), 1);
            for (int i = 1; i <= 16; i++) begin
                wr_en = 1'b1; din = 8'(i); step();
                check("ae_sweep", 32'(ae), 32'(i <= int'(pe_th)));
            end
            wr_en = 1'b0;
        end
        pe_th = 5'd3;

        // Reset mid-stream at count 9.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            wr_en = 1'b1; din = 8'(8'h80 + i); step();
        end
        wr_en = 1'b0;
        check("pre_rst_count", 32'(count), 9);
        do_reset();
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_dout", 32'(dout), 0);
        wr_en = 1'b1; din = 8'h33; step(); wr_en = 1'b0;
        check("post_rst_dout", 32'(dout), 32'h33);
        check("post_rst_valid", 32'(dout_valid), 1);
`ifdef SYNC_FIFO_PARITY_EN
        check("parity_ok", 32'(perr), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
